// File: rtl/traffic_pkg.sv
// traffic_pkg: shared encodings for the two-street traffic light controller.
//   light_t : per-street light colour driven by the light FSM (11 is illegal)
//   state_t : light FSM state encodings S0..S3
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// traffic_sensor_conditioner_if: bundles the sensor, light and status signals
// of the sensor conditioner.
//   sensor_a_raw/sensor_b_raw : raw detector levels (asynchronous, bouncy)
//   la/lb                     : light colours from the FSM
//   ta/tb                     : clean traffic-present levels
//   car_event_a/car_event_b   : one-cycle arrival pulses
//   cars_waiting_a/_b         : arrivals since each street was last green
// The master modport is the environment; the slave modport is the conditioner.
interface traffic_sensor_conditioner_if
    import traffic_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic             sensor_a_raw;
    logic             sensor_b_raw;
    light_t           la;
    light_t           lb;
    logic             ta;
    logic             tb;
    logic             car_event_a;
    logic             car_event_b;
    logic [CNT_W-1:0] cars_waiting_a;
    logic [CNT_W-1:0] cars_waiting_b;

    modport master (
        output sensor_a_raw, sensor_b_raw, la, lb,
        input  ta, tb, car_event_a, car_event_b, cars_waiting_a, cars_waiting_b
    );

    modport slave (
        input  sensor_a_raw, sensor_b_raw, la, lb,
        output ta, tb, car_event_a, car_event_b, cars_waiting_a, cars_waiting_b
    );

endinterface

// File: rtl/sensor_debounce.sv
// sensor_debounce: one street's detector path -- two-flop synchronizer,
// stable-count debounce, post-release hold timer.
//   clk, reset : clock, synchronous active-high reset
//   raw        : asynchronous bouncy detector input
//   present    : registered debounced level OR hold active
//   arrive     : strobe, high during the cycle whose closing edge raises the
//                debounced level (derived from registers only)
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic present,
    output logic arrive
);

    localparam int STABLE_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W   = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LOAD   = HOLD_W'(HOLD_CYCLES);

    logic                s1_r;
    logic                s2_r;
    logic                deb_r;
    logic                present_r;
    logic [STABLE_W-1:0] stable_cnt_r;
    logic [HOLD_W-1:0]   hold_r;

    logic                deb_s;
    logic                rise_s;
    logic                fall_s;
    logic                present_s;
    logic [STABLE_W-1:0] stable_cnt_s;
    logic [HOLD_W-1:0]   hold_s;

    // Next-state for debounce level, stable counter and hold timer.
    always_comb begin
        deb_s        = deb_r;
        stable_cnt_s = stable_cnt_r;
        rise_s       = 1'b0;
        fall_s       = 1'b0;
        if (s2_r == deb_r) begin
            stable_cnt_s = '0;
        end else if (stable_cnt_r == STABLE_LAST) begin
            deb_s        = s2_r;
            stable_cnt_s = '0;
            rise_s       = s2_r;
            fall_s       = ~s2_r;
        end else begin
            stable_cnt_s = stable_cnt_r + STABLE_W'(1);
        end

        if (fall_s) begin
            hold_s = HOLD_LOAD;
        end else if (rise_s) begin
            hold_s = '0;
        end else if (hold_r != '0) begin
            hold_s = hold_r - HOLD_W'(1);
        end else begin
            hold_s = hold_r;
        end

        // Registered so that present has no path from any input port.
        present_s = deb_s | (hold_s != '0);
    end

    // Synchronizer, debounce, hold and present registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r         <= 1'b0;
            s2_r         <= 1'b0;
            deb_r        <= 1'b0;
            stable_cnt_r <= '0;
            hold_r       <= '0;
            present_r    <= 1'b0;
        end else begin
            s1_r         <= raw;
            s2_r         <= s1_r;
            deb_r        <= deb_s;
            stable_cnt_r <= stable_cnt_s;
            hold_r       <= hold_s;
            present_r    <= present_s;
        end
    end

    assign present = present_r;
    assign arrive  = rise_s;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: turns raw street A/B detectors into TA/TB for
// the light FSM, pulses car_event on each debounced arrival and counts the
// arrivals seen while each street is not green.
//   clk, reset : clock, synchronous active-high reset
//   sens       : slave side of traffic_sensor_conditioner_if (CNT_W must
//                match this module's CNT_W)
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int CNT_W           = 8
) (
    input logic                          clk,
    input logic                          reset,
    traffic_sensor_conditioner_if.slave  sens
);

    logic             present_a_s;
    logic             present_b_s;
    logic             arrive_a_s;
    logic             arrive_b_s;
    logic             event_a_r;
    logic             event_b_r;
    logic [CNT_W-1:0] count_a_r;
    logic [CNT_W-1:0] count_b_r;

    // Green clears and wins over an arrival; the count saturates. Code 11 is
    // treated as not green because only GREEN clears.
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cnt,
        input light_t           light,
        input logic             arrive
    );
        logic [CNT_W-1:0] result;
        if (light == GREEN) begin
            result = '0;
        end else if (arrive && (cnt != {CNT_W{1'b1}})) begin
            result = cnt + CNT_W'(1);
        end else begin
            result = cnt;
        end
        return result;
    endfunction

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_deb_a (
        .clk    (clk),
        .reset  (reset),
        .raw    (sens.sensor_a_raw),
        .present(present_a_s),
        .arrive (arrive_a_s)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_deb_b (
        .clk    (clk),
        .reset  (reset),
        .raw    (sens.sensor_b_raw),
        .present(present_b_s),
        .arrive (arrive_b_s)
    );

    // Arrival pulses and waiting-car counters, updated on the debounce edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            event_a_r <= 1'b0;
            event_b_r <= 1'b0;
            count_a_r <= '0;
            count_b_r <= '0;
        end else begin
            event_a_r <= arrive_a_s;
            event_b_r <= arrive_b_s;
            count_a_r <= next_count(count_a_r, sens.la, arrive_a_s);
            count_b_r <= next_count(count_b_r, sens.lb, arrive_b_s);
        end
    end

    assign sens.ta             = present_a_s;
    assign sens.tb             = present_b_s;
    assign sens.car_event_a    = event_a_r;
    assign sens.car_event_b    = event_b_r;
    assign sens.cars_waiting_a = count_a_r;
    assign sens.cars_waiting_b = count_b_r;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// tb_traffic_sensor_conditioner: self-checking bench for the sensor
// conditioner with default parameters. Every cycle is compared against a
// window-based reference model; a vector table and hand-written sequences
// check latency, glitch rejection, hold, saturation and reset corners.
module tb_traffic_sensor_conditioner;
    import traffic_pkg::*;

    localparam int D    = 4;
    localparam int H    = 8;
    localparam int CW   = 8;
    localparam int CMAX = 255;
    localparam int NONE = 1000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    traffic_sensor_conditioner_if #(.CNT_W(CW)) sens();

    traffic_sensor_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .CNT_W          (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sens (sens)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state per street (0 = A, 1 = B).
    // m_hist[s][j] is the raw value sampled j+1 edges ago.
    int m_hist [2][8];
    int m_deb  [2];
    int m_age  [2];   // edges since the last debounced fall, NONE if none
    int m_cnt  [2];
    int m_evt  [2];
    int m_ta   [2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // The debounced level flips when the last D synchronized samples
    // (raw delayed by two edges) all disagree with it.
    task automatic model_edge(input int s, input bit rst_i, input bit raw, input light_t lt);
        bit all_diff;
        bit rose;
        bit fell;
        if (rst_i) begin
            for (int j = 0; j < 8; j++) m_hist[s][j] = 0;
            m_deb[s] = 0; m_age[s] = NONE; m_cnt[s] = 0; m_evt[s] = 0; m_ta[s] = 0;
        end else begin
            all_diff = 1'b1;
            for (int j = 1; j <= D; j++) begin
                if (m_hist[s][j] == m_deb[s]) all_diff = 1'b0;
            end
            rose = all_diff && (m_deb[s] == 0);
            fell = all_diff && (m_deb[s] == 1);
            if (all_diff) m_deb[s] = 1 - m_deb[s];
            if (fell) m_age[s] = 0;
            else if (m_age[s] < NONE) m_age[s]++;
            m_ta[s]  = (m_deb[s] == 1 || m_age[s] < H) ? 1 : 0;
            m_evt[s] = rose ? 1 : 0;
            if (lt == GREEN) m_cnt[s] = 0;
            else if (rose && m_cnt[s] < CMAX) m_cnt[s]++;
            for (int j = 7; j > 0; j--) m_hist[s][j] = m_hist[s][j-1];
            m_hist[s][0] = raw ? 1 : 0;
        end
    endtask

    // One clock: drive at negedge, model the posedge, compare at next negedge.
    task automatic step(input bit r, input bit ra, input bit rb, input light_t la_i, input light_t lb_i);
        reset             = r;
        sens.sensor_a_raw = ra;
        sens.sensor_b_raw = rb;
        sens.la           = la_i;
        sens.lb           = lb_i;
        @(posedge clk);
        model_edge(0, r, ra, la_i);
        model_edge(1, r, rb, lb_i);
        @(negedge clk);
        check("model_ta",    int'(sens.ta),             m_ta[0]);
        check("model_tb",    int'(sens.tb),             m_ta[1]);
        check("model_ev_a",  int'(sens.car_event_a),    m_evt[0]);
        check("model_ev_b",  int'(sens.car_event_b),    m_evt[1]);
        check("model_cnt_a", int'(sens.cars_waiting_a), m_cnt[0]);
        check("model_cnt_b", int'(sens.cars_waiting_b), m_cnt[1]);
    endtask

    // A raw pulse of 'hi' high steps followed by 'lo' low steps on one street.
    task automatic pulse(input int s, input int hi, input int lo, input light_t lt);
        for (int i = 0; i < hi + lo; i++) begin
            if (s == 0) step(1'b0, (i < hi), 1'b0, lt, RED);
            else        step(1'b0, 1'b0, (i < hi), RED, lt);
        end
    endtask

    typedef struct {
        bit     ra;
        bit     rb;
        light_t la;
        light_t lb;
        int     e_ta;
        int     e_ev_a;
        int     e_cnt_a;
        int     e_tb;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int acc;
        int n;
        bit ra_r;
        bit rb_r;
        light_t la_r;
        light_t lb_r;

        // Raw A held high with la=RED: rise on the 6th edge, then green clears.
        vecs[0] = '{1'b1, 1'b0, RED, RED, 0, 0, 0, 0};
        vecs[1] = '{1'b1, 1'b0, RED, RED, 0, 0, 0, 0};
        vecs[2] = '{1'b1, 1'b0, RED, RED, 0, 0, 0, 0};
        vecs[3] = '{1'b1, 1'b0, RED, RED, 0, 0, 0, 0};
        vecs[4] = '{1'b1, 1'b0, RED, RED, 0, 0, 0, 0};
        vecs[5] = '{1'b1, 1'b0, RED, RED, 1, 1, 1, 0};
        vecs[6] = '{1'b1, 1'b0, RED, RED, 1, 0, 1, 0};
        vecs[7] = '{1'b1, 1'b0, GREEN, RED, 1, 0, 0, 0};

        sens.sensor_a_raw = 1'b0;
        sens.sensor_b_raw = 1'b0;
        sens.la           = RED;
        sens.lb           = RED;

        // Reset then 20 idle cycles.
        step(1'b1, 1'b0, 1'b0, RED, RED);
        check("reset_ta",    int'(sens.ta),             0);
        check("reset_cnt_a", int'(sens.cars_waiting_a), 0);
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, RED, RED);
            acc += int'(sens.ta) + int'(sens.tb) + int'(sens.car_event_a) + int'(sens.car_event_b)
                 + int'(sens.cars_waiting_a) + int'(sens.cars_waiting_b);
        end
        check("idle_quiet", acc, 0);

        // Vector table.
        step(1'b1, 1'b0, 1'b0, RED, RED);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, vecs[i].ra, vecs[i].rb, vecs[i].la, vecs[i].lb);
            check("vec_ta",    int'(sens.ta),             vecs[i].e_ta);
            check("vec_ev_a",  int'(sens.car_event_a),    vecs[i].e_ev_a);
            check("vec_cnt_a", int'(sens.cars_waiting_a), vecs[i].e_cnt_a);
            check("vec_tb",    int'(sens.tb),             vecs[i].e_tb);
        end

        // 3-sample glitch is ignored.
        step(1'b1, 1'b0, 1'b0, RED, RED);
        acc = 0;
        for (int i = 0; i < 13; i++) begin
            step(1'b0, (i < 3), 1'b0, RED, RED);
            acc += int'(sens.ta) + int'(sens.car_event_a);
        end
        check("glitch3_ignored", acc, 0);
        check("glitch3_count", int'(sens.cars_waiting_a), 0);

        // 4-sample pulse passes: ta high for D cycles of deb plus H of hold.
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, (i < 4), 1'b0, RED, RED);
            acc += int'(sens.ta);
        end
        check("pulse4_ta_cycles", acc, D + H);
        check("pulse4_count", int'(sens.cars_waiting_a), 1);

        // Re-assert during the hold: ta never drops, second arrival counted.
        step(1'b1, 1'b0, 1'b0, RED, RED);
        acc = 0;
        n = 0;
        for (int i = 0; i < 29; i++) begin
            step(1'b0, (i < 10) || (i >= 17), 1'b0, RED, RED);
            if (i >= 5 && sens.ta == 1'b0) acc++;
            n += int'(sens.car_event_a);
        end
        check("reassert_ta_drops", acc, 0);
        check("reassert_events", n, 2);
        check("reassert_count", int'(sens.cars_waiting_a), 2);

        // 300 arrivals saturate at 255; green clears.
        step(1'b1, 1'b0, 1'b0, RED, RED);
        n = 0;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 10; i++) begin
                step(1'b0, (i < 5), 1'b0, RED, RED);
                n += int'(sens.car_event_a);
            end
        end
        check("sat_events", n, 300);
        check("sat_count", int'(sens.cars_waiting_a), 255);
        step(1'b0, 1'b0, 1'b0, GREEN, RED);
        check("green_clears", int'(sens.cars_waiting_a), 0);
        pulse(0, 5, 5, RED);
        pulse(0, 5, 5, RED);
        check("count_two", int'(sens.cars_waiting_a), 2);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, RED, RED);
        step(1'b0, 1'b1, 1'b0, GREEN, RED);
        check("green_arrival_event", int'(sens.car_event_a), 1);
        check("green_arrival_count", int'(sens.cars_waiting_a), 0);

        // Reset mid-hold on B with five cars waiting.
        step(1'b1, 1'b0, 1'b0, RED, RED);
        for (int k = 0; k < 4; k++) pulse(1, 5, 5, RED);
        pulse(1, 5, 8, RED);
        step(1'b0, 1'b0, 1'b1, RED, RED);
        check("midhold_tb", int'(sens.tb), 1);
        check("midhold_cnt_b", int'(sens.cars_waiting_b), 5);
        step(1'b1, 1'b0, 1'b1, RED, RED);
        check("rst_tb", int'(sens.tb), 0);
        check("rst_cnt_b", int'(sens.cars_waiting_b), 0);
        check("rst_ev_b", int'(sens.car_event_b), 0);
        n = 0;
        while (sens.tb == 1'b0 && n < 20) begin
            step(1'b0, 1'b0, 1'b1, RED, RED);
            n++;
        end
        check("release_latency", n, 6);

        // Randomized run against the model.
        step(1'b1, 1'b0, 1'b0, RED, RED);
        ra_r = 1'b0; rb_r = 1'b0; la_r = RED; lb_r = YELLOW;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) ra_r = ~ra_r;
            if ($urandom_range(0, 5) == 0) rb_r = ~rb_r;
            if ($urandom_range(0, 15) == 0) la_r = light_t'(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 15) == 0) lb_r = light_t'(2'($urandom_range(0, 3)));
            step(($urandom_range(0, 399) == 0), ra_r, rb_r, la_r, lb_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_conditioner.md
Name: traffic_sensor_conditioner

Overview:
Upstream stage of the two-street traffic light controller. It turns the raw, asynchronous, bouncy car-detector inputs for street A and street B into the clean TA/TB "traffic present" levels that the light FSM consumes. It also counts cars that arrive while each street is not green, for status and logging. It watches the FSM's light outputs (LA/LB) to know when to clear each count.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed before the debounced level changes (>=1)
HOLD_CYCLES, 8, cycles TA/TB stay high after the debounced sensor falls (>=0)
CNT_W, 8, width of each waiting-car counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
sensor_a_raw  in  1  street A detector, asynchronous, may bounce
sensor_b_raw  in  1  street B detector, asynchronous, may bounce
la  in  2  street A light from the FSM (GREEN=00, YELLOW=01, RED=10)
lb  in  2  street B light from the FSM
ta  out  1  street A traffic present, to the FSM
tb  out  1  street B traffic present, to the FSM
car_event_a  out  1  one-cycle pulse on each debounced A arrival
car_event_b  out  1  one-cycle pulse on each debounced B arrival
cars_waiting_a  out  CNT_W  A arrivals since A was last green
cars_waiting_b  out  CNT_W  B arrivals since B was last green

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset values: all synchronizer flops, debounced levels, stable counters and hold timers are 0. Outputs: ta=0, tb=0, car_event_*=0, cars_waiting_*=0.
- Reset mid-operation: every output is 0 after the reset edge. No hold and no event is generated by reset dropping the debounced level.
- Streets A and B are processed independently and identically. The steps below describe one street.
- Synchronizer: two flops, s1 then s2.
- Debounce:
  - stable_cnt is cleared whenever s2 equals the debounced level deb.
  - Otherwise stable_cnt increments.
  - When s2 differs from deb and stable_cnt equals DEBOUNCE_CYCLES-1, deb takes the value of s2 and stable_cnt clears.
  - A raw pulse shorter than DEBOUNCE_CYCLES synchronized samples is ignored completely.
- Latency: a raw input held high from a given edge produces a rise of deb, and therefore of ta, on the 2+DEBOUNCE_CYCLES-th edge that samples it high. With defaults this is 6 edges. Falling has the same latency before the hold starts.
- Hold timer:
  - The edge on which deb falls loads hold with HOLD_CYCLES.
  - hold decrements by 1 per cycle while it is nonzero.
  - The edge on which deb rises clears hold.
- ta = deb OR (hold != 0). ta is driven from registers only, with no combinational path from any input.
- With defaults, ta falls exactly HOLD_CYCLES edges after deb falls. With HOLD_CYCLES=0, ta falls together with deb.
- car_event: a registered pulse, high for exactly the cycle after the edge on which deb rises. It is high on the same cycle as the ta rise, unless ta was already high because of hold. It is never high for 2 consecutive cycles.
- Counter:
  - While the street's light equals GREEN, the counter is forced to 0 and arrivals are not counted. Clear wins over a simultaneous arrival.
  - Otherwise each arrival increments the counter on the edge where deb rises.
  - The counter saturates at 2^CNT_W-1 with no wrap.
  - Light code 11 is illegal and is treated as "not green".
- car_event pulses regardless of the light colour.

Decomposition:
- Shared package traffic_pkg holds:
  - light encodings GREEN/YELLOW/RED as a 2-bit typedef light_t;
  - FSM state encodings S0–S3.
- The light FSM and this block both import traffic_pkg, so the la/lb ports are typed light_t.
- One sub-module, sensor_debounce (parameters DEBOUNCE_CYCLES and HOLD_CYCLES), contains synchronizer, debounce, hold and edge pulse. It outputs present and arrive, and is instantiated twice.
- The counters and the light compare live in the top level.

Test Plan:
- Reset, then raw inputs held 0 for 20 cycles -> ta=tb=0, no car_event, counts 0 throughout.
- sensor_a_raw rises and stays high, lb irrelevant, la=RED -> ta rises on the 6th edge, car_event_a high exactly 1 cycle at that point, cars_waiting_a=1.
- sensor_a_raw glitch high for 3 cycles (defaults) -> ta stays 0, no event, count unchanged. Same test with a 4-cycle high pulse -> ta rises.
- Sensor A high, then low -> ta stays high 8 cycles after deb falls. Re-assert during the hold -> ta never drops, and a second car_event_a with count 2 if la is not green.
- la=RED, 300 arrivals on A with CNT_W=8 -> count saturates at 255. Then la=GREEN for 1 cycle -> count 0. An arrival on the same cycle la=GREEN -> count stays 0 and car_event_a still pulses.
- Reset asserted mid-hold, with tb high and cars_waiting_b=5 -> the next cycle shows tb=0, cars_waiting_b=0, no event. After reset releases with the raw input still high -> tb rises after 6 edges.
